// File: rtl/elevator_car.sv
// elevator_car
// ------------
// Car-and-shaft plant for the elevator controller. Takes the controller's
// motion and door commands, moves a model car between floors 1..3 with a
// fixed travel time per floor, runs a timed door, and reports arrival,
// position and door status back. Illegal commands raise a sticky fault.
//
// Parameters
//   TRAVEL_CYCLES  cycles to move one floor (>= 1)
//   DOOR_CYCLES    cycles to fully open or fully close the door (>= 1)
//
// Ports
//   clk                 in   system clock, rising edge
//   rst                 in   synchronous, active-low reset
//   elevator_direction  in   2  00 stop, 01 up, 10 down, 11 illegal
//   door_open           in   1  1 = open / hold open, 0 = close
//   elevator_arrived    out  1  one-cycle pulse on reaching a floor
//   floor_sensor        out  3  one-hot position, 000 between floors
//   current_floor       out  2  last floor reached, 1..3
//   moving              out  1  car is travelling
//   door_closed         out  1  door fully closed
//   cmd_fault           out  1  sticky illegal-command flag
module elevator_car #(
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] elevator_direction,
  input  logic       door_open,
  output logic       elevator_arrived,
  output logic [2:0] floor_sensor,
  output logic [1:0] current_floor,
  output logic       moving,
  output logic       door_closed,
  output logic       cmd_fault
);

  localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_LAST   = CW'(DOOR_CYCLES - 1);

  localparam logic [1:0] DIR_STOP    = 2'b00;
  localparam logic [1:0] DIR_UP      = 2'b01;
  localparam logic [1:0] DIR_DOWN    = 2'b10;
  localparam logic [1:0] DIR_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    PARKED,
    MOVE,
    DOOR_OPENING,
    DOOR_HELD,
    DOOR_CLOSING
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          dir_up;

  function automatic logic [2:0] onehot(input logic [1:0] floor);
    return 3'b001 << (floor - 2'd1);
  endfunction

  // The counter counts the edges already spent in the current state; an
  // action lasting N cycles completes on the edge where it reads N-1, so it
  // never exceeds its limit and never wraps.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and sampled on the clock edge; every
    // register in this block is state, so all assignments are non-blocking.
    if (!rst) begin
      state            <= PARKED;
      cnt              <= '0;
      dir_up           <= 1'b0;
      elevator_arrived <= 1'b0;
      floor_sensor     <= 3'b001;
      current_floor    <= 2'd1;
      moving           <= 1'b0;
      door_closed      <= 1'b1;
      cmd_fault        <= 1'b0;
    end else begin
      elevator_arrived <= 1'b0;

      // Any motion request with the door not fully closed is rejected.
      if (!door_closed && elevator_direction != DIR_STOP) cmd_fault <= 1'b1;

      case (state)
        PARKED: begin
          if (door_open) begin
            state       <= DOOR_OPENING;
            cnt         <= '0;
            door_closed <= 1'b0;
          end else if (elevator_direction == DIR_UP && current_floor != 2'd3) begin
            state        <= MOVE;
            cnt          <= '0;
            dir_up       <= 1'b1;
            moving       <= 1'b1;
            floor_sensor <= 3'b000;
          end else if (elevator_direction == DIR_DOWN && current_floor != 2'd1) begin
            state        <= MOVE;
            cnt          <= '0;
            dir_up       <= 1'b0;
            moving       <= 1'b1;
            floor_sensor <= 3'b000;
          end else if (elevator_direction != DIR_STOP) begin
            // Up at the top, down at the bottom, or the illegal code.
            cmd_fault <= 1'b1;
          end
        end

        MOVE: begin
          // The latched direction rules; new commands are only checked.
          if (door_open || elevator_direction == DIR_ILLEGAL) cmd_fault <= 1'b1;
          if (cnt == TRAVEL_LAST) begin
            state            <= PARKED;
            cnt              <= '0;
            moving           <= 1'b0;
            elevator_arrived <= 1'b1;
            if (dir_up) begin
              current_floor <= current_floor + 2'd1;
              floor_sensor  <= onehot(current_floor + 2'd1);
            end else begin
              current_floor <= current_floor - 2'd1;
              floor_sensor  <= onehot(current_floor - 2'd1);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DOOR_OPENING: begin
          if (cnt == DOOR_LAST) begin
            state <= DOOR_HELD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DOOR_HELD: begin
          if (!door_open) begin
            state <= DOOR_CLOSING;
            cnt   <= '0;
          end
        end

        DOOR_CLOSING: begin
          // Safety reopen takes priority, even on the final closing cycle.
          if (door_open) begin
            state <= DOOR_OPENING;
            cnt   <= '0;
          end else if (cnt == DOOR_LAST) begin
            state       <= PARKED;
            cnt         <= '0;
            door_closed <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= PARKED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/elevator_car.md
# elevator_car

Behavioural car-and-shaft responder for the `elevator` controller. It consumes the controller's `elevator_direction` and `door_open` commands, moves a model car between floors 1–3 with a fixed per-floor travel time, and returns the `elevator_arrived` pulse and floor-position sensors the controller expects. It is used as the plant in closed-loop benches and as the synthesizable shaft model on the demo board. It also flags illegal commands.

## Interface
Parameters:
- `TRAVEL_CYCLES`, default 4: cycles to move one floor; must be ≥1.
- `DOOR_CYCLES`, default 3: cycles to fully open or fully close the door; must be ≥1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `elevator_direction`  in  2  motion command: 00 stop, 01 up, 10 down, 11 illegal.
- `door_open`  in  1  door command: 1 = open/hold open, 0 = close.
- `elevator_arrived`  out  1  one-cycle pulse when the car reaches a floor.
- `floor_sensor`  out  3  one-hot position (bit0 = floor 1); 000 while between floors.
- `current_floor`  out  2  last floor reached, encoded 1..3.
- `moving`  out  1  car is travelling.
- `door_closed`  out  1  door fully closed.
- `cmd_fault`  out  1  sticky illegal-command flag; cleared only by reset.

## Operation
- All outputs are registered. Reset values: `current_floor`=1, `floor_sensor`=001, `door_closed`=1, `moving`=0, `elevator_arrived`=0, `cmd_fault`=0. Reset state is PARKED with the counter at 0.
- Reset wins over everything at any point, including mid-travel and mid-door. The car snaps to floor 1 with the door closed.
- State machine: PARKED, MOVE, DOOR_OPENING, DOOR_HELD, DOOR_CLOSING.
- PARKED, priority order:
  1. `door_open`=1 → DOOR_OPENING.
  2. dir=01 and floor<3 → MOVE up.
  3. dir=10 and floor>1 → MOVE down.
  4. dir=01 at floor 3, dir=10 at floor 1, or dir=11 → set `cmd_fault` and stay.
  5. dir=00 → stay.
- MOVE:
  - Direction is latched on entry. The car always completes the current floor; command changes are ignored.
  - `door_open`=1 or dir=11 during MOVE sets `cmd_fault` and is otherwise ignored.
  - After TRAVEL_CYCLES cycles: `current_floor` ±1, `floor_sensor` set to the new floor, `elevator_arrived`=1 for exactly one cycle, `moving`=0, next state PARKED.
- DOOR_OPENING: `door_closed`=0 from the entry edge. After DOOR_CYCLES cycles → DOOR_HELD.
- DOOR_HELD: stay while `door_open`=1. On `door_open`=0 → DOOR_CLOSING.
- DOOR_CLOSING:
  - After DOOR_CYCLES cycles → `door_closed`=1 and PARKED.
  - If `door_open` reasserts, reverse to DOOR_OPENING with the counter restarted (safety reopen).
- Any nonzero `elevator_direction` while `door_closed`=0 sets `cmd_fault` and is ignored.
- A single counter is shared by travel and door timing. Width is clog2(max(TRAVEL_CYCLES, DOOR_CYCLES)+1). It is cleared on every state entry and never wraps.

## Timing
- Move accepted at edge N (PARKED, legal dir sampled):
  - From edge N: `moving`=1 and `floor_sensor`=000.
  - At edge N+TRAVEL_CYCLES: new floor on `current_floor`/`floor_sensor`, `elevator_arrived`=1, `moving`=0.
  - At edge N+TRAVEL_CYCLES+1: `elevator_arrived`=0. A new command can be accepted at this same edge.
- A held dir=01 from floor 1 with TRAVEL_CYCLES=4 gives arrival pulses at N+4 (floor 2) and N+9 (floor 3), then `cmd_fault` at N+10.
- Door accepted at edge M:
  - `door_closed`=0 from edge M; DOOR_HELD at M+DOOR_CYCLES.
  - If `door_open` drops and is sampled at edge K in DOOR_HELD: `door_closed`=1 at K+DOOR_CYCLES.
- `cmd_fault` rises at the edge that samples the illegal command.
- `elevator_arrived` is never asserted on reset, on door transitions, or on a rejected command.

## Test plan
- Reset: hold `rst`=0 for one edge mid-anything → `floor_sensor`=001, `current_floor`=1, `door_closed`=1, all other outputs 0.
- Up travel (TRAVEL_CYCLES=4): dir=01 held from floor 1 → `moving`=1 for 4 cycles; arrival pulses at N+4 (floor 2, sensor 010) and N+9 (floor 3, sensor 100); `cmd_fault`=1 at N+10 with the car still at floor 3.
- Down travel with a mid-move command change: from floor 3, dir=10 then dir=01 two cycles later → car still arrives at floor 2 at N+4; the next move is up.
- Door cycle (DOOR_CYCLES=3) at floor 2:
  - `door_open`=1 → `door_closed`=0 at M, DOOR_HELD at M+3.
  - dir=10 while held → `cmd_fault`=1, no motion.
  - Drop `door_open` → `door_closed`=1 three cycles later.
- Safety reopen: reassert `door_open` one cycle into DOOR_CLOSING → `door_closed` stays 0; a full 3-cycle reopen, then a close after deassert.
- Reset mid-travel: `rst`=0 two cycles into a floor 1→2 move → next edge `floor_sensor`=001, `moving`=0, no arrival pulse.
